// File: rtl/eth_wb_cmd_master.sv
// rtl/eth_wb_cmd_master.sv - Wishbone classic master with command FIFO, ack timeout and sticky MAC interrupt
module eth_wb_cmd_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_adr,
    input  logic [DATA_W-1:0] cmd_dat,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_dat,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_int_i,
    input  logic              irq_clr,
    output logic              irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int EW = 1 + ADDR_W + DATA_W;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t        state;
    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;
    logic [CW-1:0] cnt;
    logic          int_q;
    logic          int_prev;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign head      = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_we, cmd_adr, cmd_dat};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        {wb_we_o, wb_adr_o, wb_dat_o} <= head;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        cnt      <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // Ack is checked first so it wins over a simultaneous timeout.
                    if (wb_ack_i) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        rsp_dat   <= wb_we_o ? '0 : wb_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else if (cnt == CNT_LAST) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        rsp_dat   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Rising edge of the registered interrupt sets the flag; set beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_q    <= 1'b0;
            int_prev <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            int_q    <= wb_int_i;
            int_prev <= int_q;
            if (int_q && !int_prev) begin
                irq_o <= 1'b1;
            end else if (irq_clr) begin
                irq_o <= 1'b0;
            end
        end
    end
endmodule
